// File: rtl/stk_al_ctrl_pkg.sv
// stk_pkg: shared constants and types for the stack-entry pointer allocator.
package stk_pkg;

    localparam int PTR_N_DEF = 32;
    localparam int PTR_W     = $clog2(PTR_N_DEF);

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } al_state_t;

endpackage

// File: rtl/stk_al_ctrl_if.sv
// stk_al_ctrl_if: allocate/free handshake between the pipeline (master) and the allocator (slave).
interface stk_al_ctrl_if #(
    parameter int PTR_N = stk_pkg::PTR_N_DEF
);
    localparam int PTR_W = $clog2(PTR_N);

    logic             i_alloc_req;
    logic             o_alloc_vld;
    logic [PTR_W-1:0] o_alloc_ptr;
    logic             i_free_vld;
    logic [PTR_W-1:0] i_free_ptr;
    logic             o_empty;
    logic             o_busy;
    logic [PTR_W:0]   o_free_cnt;
    logic             o_err;

    modport master (
        output i_alloc_req, i_free_vld, i_free_ptr,
        input  o_alloc_vld, o_alloc_ptr, o_empty, o_busy, o_free_cnt, o_err
    );

    modport slave (
        input  i_alloc_req, i_free_vld, i_free_ptr,
        output o_alloc_vld, o_alloc_ptr, o_empty, o_busy, o_free_cnt, o_err
    );

endinterface

// File: rtl/stk_al_ctrl_fl.sv
// stk_al_fl: free-list storage, one synchronous write port and one combinational read port.
// Contents are deliberately not reset; the controller's init sequence fills every slot.
module stk_al_fl #(
    parameter int PTR_N = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(PTR_N)-1:0] wr_addr,
    input  logic [$clog2(PTR_N)-1:0] wr_data,
    input  logic [$clog2(PTR_N)-1:0] rd_addr,
    output logic [$clog2(PTR_N)-1:0] rd_data
);
    localparam int PTR_W = $clog2(PTR_N);

    logic [PTR_W-1:0] mem [PTR_N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stk_al_ctrl.sv
// stk_al_ctrl: stack-entry pointer allocator built on a circular free-list FIFO.
// Define STK_AL_CTRL_DOUBLE_FREE_CHK_EN to track allocated pointers and reject double frees.
module stk_al_ctrl
    import stk_pkg::*;
#(
    parameter int PTR_N = PTR_N_DEF
) (
    input  logic          clk,
    input  logic          arst_n,
    stk_al_ctrl_if.slave  bus
);
    localparam int               PTR_W    = $clog2(PTR_N);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(PTR_N - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PTR_N);

    al_state_t        state;
    al_state_t        state_nxt;
    logic [PTR_W-1:0] init_cnt;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] free_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             empty_q;
    logic             busy_q;
    logic             err_q;
    logic             grant;
    logic             free_ok;
    logic             free_drop;
    logic             fl_wr_en;
    logic [PTR_W-1:0] fl_wr_addr;
    logic [PTR_W-1:0] fl_wr_data;
    logic [PTR_W-1:0] fl_rd_data;

`ifdef STK_AL_CTRL_DOUBLE_FREE_CHK_EN
    logic [PTR_N-1:0] alloc_map;
`endif

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_cnt == LAST_IDX) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    // INIT owns the write port to seed slot k with value k; READY hands it to returned pointers.
    always_comb begin
        grant      = 1'b0;
        free_ok    = 1'b0;
        free_drop  = 1'b0;
        fl_wr_en   = 1'b0;
        fl_wr_addr = tail;
        fl_wr_data = bus.i_free_ptr;
        case (state)
            INIT: begin
                fl_wr_en   = 1'b1;
                fl_wr_addr = init_cnt;
                fl_wr_data = init_cnt;
            end
            READY: begin
                grant = bus.i_alloc_req & ~empty_q;
                if (bus.i_free_vld) begin
                    if (free_cnt == FULL_CNT) begin
                        free_drop = 1'b1;
`ifdef STK_AL_CTRL_DOUBLE_FREE_CHK_EN
                    end else if (!alloc_map[bus.i_free_ptr]) begin
                        free_drop = 1'b1;
`endif
                    end else begin
                        free_ok = 1'b1;
                    end
                end
                fl_wr_en = free_ok;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_nxt = free_cnt;
        if (state == INIT) begin
            cnt_nxt = (init_cnt == LAST_IDX) ? FULL_CNT : '0;
        end else if (free_ok && !grant) begin
            cnt_nxt = free_cnt + 1'b1;
        end else if (grant && !free_ok) begin
            cnt_nxt = free_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            init_cnt <= '0;
            head     <= '0;
            tail     <= '0;
            free_cnt <= '0;
            empty_q  <= 1'b1;
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
            if (grant)         head     <= head + 1'b1;
            if (free_ok)       tail     <= tail + 1'b1;
            if (free_drop)     err_q    <= 1'b1;
            free_cnt <= cnt_nxt;
            empty_q  <= (cnt_nxt == '0) || (state_nxt == INIT);
            busy_q   <= (state_nxt == INIT);
        end
    end

`ifdef STK_AL_CTRL_DOUBLE_FREE_CHK_EN
    always_ff @(posedge clk) begin
        if (!arst_n || state == INIT) begin
            alloc_map <= '0;
        end else begin
            if (grant)   alloc_map[fl_rd_data]     <= 1'b1;
            if (free_ok) alloc_map[bus.i_free_ptr] <= 1'b0;
        end
    end
`endif

    stk_al_fl #(
        .PTR_N (PTR_N)
    ) u_fl (
        .clk     (clk),
        .wr_en   (fl_wr_en),
        .wr_addr (fl_wr_addr),
        .wr_data (fl_wr_data),
        .rd_addr (head),
        .rd_data (fl_rd_data)
    );

    assign bus.o_alloc_vld = grant;
    assign bus.o_alloc_ptr = fl_rd_data;
    assign bus.o_empty     = empty_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_free_cnt  = free_cnt;
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_stk_al_ctrl.sv
// tb_stk_al_ctrl: directed self-checking bench for the pointer allocator (PTR_N = 32).
module tb_stk_al_ctrl;

    localparam int PTR_N = 32;
    localparam int PTR_W = 5;

    logic clk = 1'b0;
    logic arst_n;
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    stk_al_ctrl_if #(.PTR_N(PTR_N)) bus ();

    stk_al_ctrl #(.PTR_N(PTR_N)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs change on the falling edge so combinational grant outputs settle before the rising edge.
    task automatic drive(input logic req, input logic fv, input logic [PTR_W-1:0] fp);
        @(negedge clk);
        bus.i_alloc_req = req;
        bus.i_free_vld  = fv;
        bus.i_free_ptr  = fp;
        #1;
    endtask

    task automatic run_init(output int cycles);
        cycles = 0;
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            cycles++;
            if (!bus.o_busy) break;
        end
    endtask

    task automatic test_reset();
        int n;
        drive(1'b1, 1'b1, 5'd3);
        arst_n = 1'b0;
        step();
        step();
        check_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL reset_busy: got %0d expected 1", bus.o_busy); else pass_cnt++;
        check_cnt++; if (bus.o_empty !== 1'b1) $display("FAIL reset_empty: got %0d expected 1", bus.o_empty); else pass_cnt++;
        check_cnt++; if (bus.o_free_cnt !== 6'd0) $display("FAIL reset_cnt: got %0d expected 0", bus.o_free_cnt); else pass_cnt++;
        check_cnt++; if (bus.o_err !== 1'b0) $display("FAIL reset_err: got %0d expected 0", bus.o_err); else pass_cnt++;
        check_cnt++; if (bus.o_alloc_vld !== 1'b0) $display("FAIL reset_vld: got %0d expected 0", bus.o_alloc_vld); else pass_cnt++;
        // Requests and frees stay asserted through INIT and must be ignored.
        n = 0;
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            n++;
            if (n == 5) begin
                check_cnt++; if (bus.o_alloc_vld !== 1'b0) $display("FAIL init_vld: got %0d expected 0", bus.o_alloc_vld); else pass_cnt++;
            end
            if (!bus.o_busy) break;
        end
        drive(1'b0, 1'b0, 5'd0);
        check_cnt++; if (n !== 32) $display("FAIL init_cycles: got %0d expected 32", n); else pass_cnt++;
        check_cnt++; if (bus.o_free_cnt !== 6'd32) $display("FAIL init_cnt: got %0d expected 32", bus.o_free_cnt); else pass_cnt++;
        check_cnt++; if (bus.o_empty !== 1'b0) $display("FAIL init_empty: got %0d expected 0", bus.o_empty); else pass_cnt++;
        check_cnt++; if (bus.o_err !== 1'b0) $display("FAIL init_err: got %0d expected 0", bus.o_err); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 5'd0);
            check_cnt++; if (bus.o_alloc_vld !== 1'b1) $display("FAIL b2b_vld[%0d]: got %0d expected 1", i, bus.o_alloc_vld); else pass_cnt++;
            check_cnt++; if (bus.o_alloc_ptr !== PTR_W'(i)) $display("FAIL b2b_ptr[%0d]: got %0d expected %0d", i, bus.o_alloc_ptr, i); else pass_cnt++;
            step();
        end
        check_cnt++; if (bus.o_empty !== 1'b1) $display("FAIL b2b_empty: got %0d expected 1", bus.o_empty); else pass_cnt++;
        check_cnt++; if (bus.o_free_cnt !== 6'd0) $display("FAIL b2b_cnt: got %0d expected 0", bus.o_free_cnt); else pass_cnt++;
        drive(1'b1, 1'b0, 5'd0);
        check_cnt++; if (bus.o_alloc_vld !== 1'b0) $display("FAIL b2b_33rd_vld: got %0d expected 0", bus.o_alloc_vld); else pass_cnt++;
        step();
        check_cnt++; if (bus.o_free_cnt !== 6'd0) $display("FAIL b2b_33rd_cnt: got %0d expected 0", bus.o_free_cnt); else pass_cnt++;
        drive(1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_empty_bypass();
        drive(1'b1, 1'b1, 5'd5);
        check_cnt++; if (bus.o_alloc_vld !== 1'b0) $display("FAIL bypass_vld: got %0d expected 0", bus.o_alloc_vld); else pass_cnt++;
        step();
        check_cnt++; if (bus.o_free_cnt !== 6'd1) $display("FAIL bypass_cnt1: got %0d expected 1", bus.o_free_cnt); else pass_cnt++;
        check_cnt++; if (bus.o_empty !== 1'b0) $display("FAIL bypass_empty0: got %0d expected 0", bus.o_empty); else pass_cnt++;
        drive(1'b1, 1'b0, 5'd0);
        check_cnt++; if (bus.o_alloc_vld !== 1'b1) $display("FAIL bypass_grant_vld: got %0d expected 1", bus.o_alloc_vld); else pass_cnt++;
        check_cnt++; if (bus.o_alloc_ptr !== 5'd5) $display("FAIL bypass_grant_ptr: got %0d expected 5", bus.o_alloc_ptr); else pass_cnt++;
        step();
        check_cnt++; if (bus.o_free_cnt !== 6'd0) $display("FAIL bypass_cnt0: got %0d expected 0", bus.o_free_cnt); else pass_cnt++;
        check_cnt++; if (bus.o_empty !== 1'b1) $display("FAIL bypass_empty1: got %0d expected 1", bus.o_empty); else pass_cnt++;
        drive(1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_simultaneous();
        int exp;
        for (int p = 10; p < 20; p++) begin
            drive(1'b0, 1'b1, PTR_W'(p));
            step();
        end
        check_cnt++; if (bus.o_free_cnt !== 6'd10) $display("FAIL simul_fill_cnt: got %0d expected 10", bus.o_free_cnt); else pass_cnt++;
        drive(1'b1, 1'b1, 5'd7);
        check_cnt++; if (bus.o_alloc_vld !== 1'b1) $display("FAIL simul_vld: got %0d expected 1", bus.o_alloc_vld); else pass_cnt++;
        check_cnt++; if (bus.o_alloc_ptr !== 5'd10) $display("FAIL simul_ptr: got %0d expected 10", bus.o_alloc_ptr); else pass_cnt++;
        step();
        check_cnt++; if (bus.o_free_cnt !== 6'd10) $display("FAIL simul_cnt: got %0d expected 10", bus.o_free_cnt); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            exp = (i < 9) ? 11 + i : 7;
            drive(1'b1, 1'b0, 5'd0);
            check_cnt++; if (bus.o_alloc_ptr !== PTR_W'(exp) || bus.o_alloc_vld !== 1'b1) $display("FAIL simul_order[%0d]: got ptr %0d vld %0d expected ptr %0d vld 1", i, bus.o_alloc_ptr, bus.o_alloc_vld, exp); else pass_cnt++;
            step();
        end
        check_cnt++; if (bus.o_empty !== 1'b1) $display("FAIL simul_drain_empty: got %0d expected 1", bus.o_empty); else pass_cnt++;
        drive(1'b0, 1'b0, 5'd0);
    endtask

`ifdef STK_AL_CTRL_DOUBLE_FREE_CHK_EN
    task automatic test_double_free();
        drive(1'b0, 1'b1, 5'd3);
        step();
        check_cnt++; if (bus.o_free_cnt !== 6'd1) $display("FAIL dfree_first_cnt: got %0d expected 1", bus.o_free_cnt); else pass_cnt++;
        check_cnt++; if (bus.o_err !== 1'b0) $display("FAIL dfree_first_err: got %0d expected 0", bus.o_err); else pass_cnt++;
        drive(1'b0, 1'b1, 5'd3);
        step();
        check_cnt++; if (bus.o_err !== 1'b1) $display("FAIL dfree_err: got %0d expected 1", bus.o_err); else pass_cnt++;
        check_cnt++; if (bus.o_free_cnt !== 6'd1) $display("FAIL dfree_cnt: got %0d expected 1", bus.o_free_cnt); else pass_cnt++;
        drive(1'b0, 1'b0, 5'd0);
        step();
        check_cnt++; if (bus.o_err !== 1'b1) $display("FAIL dfree_sticky: got %0d expected 1", bus.o_err); else pass_cnt++;
        drive(1'b1, 1'b0, 5'd0);
        check_cnt++; if (bus.o_alloc_ptr !== 5'd3) $display("FAIL dfree_drain_ptr: got %0d expected 3", bus.o_alloc_ptr); else pass_cnt++;
        step();
        drive(1'b0, 1'b0, 5'd0);
    endtask
`endif

    task automatic test_ready_reset();
        int n;
        @(negedge clk);
        arst_n = 1'b0;
        step();
        check_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL rdyrst_busy: got %0d expected 1", bus.o_busy); else pass_cnt++;
        check_cnt++; if (bus.o_err !== 1'b0) $display("FAIL rdyrst_err: got %0d expected 0", bus.o_err); else pass_cnt++;
        check_cnt++; if (bus.o_empty !== 1'b1) $display("FAIL rdyrst_empty: got %0d expected 1", bus.o_empty); else pass_cnt++;
        run_init(n);
        check_cnt++; if (n !== 32) $display("FAIL rdyrst_cycles: got %0d expected 32", n); else pass_cnt++;
        check_cnt++; if (bus.o_free_cnt !== 6'd32) $display("FAIL rdyrst_cnt: got %0d expected 32", bus.o_free_cnt); else pass_cnt++;
    endtask

    task automatic test_full_free();
        drive(1'b0, 1'b1, 5'd9);
        step();
        check_cnt++; if (bus.o_err !== 1'b1) $display("FAIL full_free_err: got %0d expected 1", bus.o_err); else pass_cnt++;
        check_cnt++; if (bus.o_free_cnt !== 6'd32) $display("FAIL full_free_cnt: got %0d expected 32", bus.o_free_cnt); else pass_cnt++;
        drive(1'b0, 1'b0, 5'd0);
        step();
        check_cnt++; if (bus.o_err !== 1'b1) $display("FAIL full_free_sticky: got %0d expected 1", bus.o_err); else pass_cnt++;
    endtask

    task automatic test_init_reset();
        int n;
        @(negedge clk);
        arst_n = 1'b0;
        step();
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check_cnt++; if (bus.o_busy !== 1'b1) $display("FAIL midinit_busy: got %0d expected 1", bus.o_busy); else pass_cnt++;
        @(negedge clk);
        arst_n = 1'b0;
        step();
        check_cnt++; if (bus.o_free_cnt !== 6'd0) $display("FAIL midinit_rst_cnt: got %0d expected 0", bus.o_free_cnt); else pass_cnt++;
        run_init(n);
        check_cnt++; if (n !== 32) $display("FAIL midinit_cycles: got %0d expected 32", n); else pass_cnt++;
        check_cnt++; if (bus.o_err !== 1'b0) $display("FAIL midinit_err: got %0d expected 0", bus.o_err); else pass_cnt++;
        check_cnt++; if (bus.o_empty !== 1'b0) $display("FAIL midinit_empty: got %0d expected 0", bus.o_empty); else pass_cnt++;
        drive(1'b1, 1'b0, 5'd0);
        check_cnt++; if (bus.o_alloc_ptr !== 5'd0) $display("FAIL midinit_first_ptr: got %0d expected 0", bus.o_alloc_ptr); else pass_cnt++;
        step();
        check_cnt++; if (bus.o_free_cnt !== 6'd31) $display("FAIL midinit_cnt31: got %0d expected 31", bus.o_free_cnt); else pass_cnt++;
        drive(1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        arst_n          = 1'b0;
        bus.i_alloc_req = 1'b0;
        bus.i_free_vld  = 1'b0;
        bus.i_free_ptr  = '0;
        test_reset();
        test_back_to_back();
        test_empty_bypass();
        test_simultaneous();
`ifdef STK_AL_CTRL_DOUBLE_FREE_CHK_EN
        test_double_free();
`endif
        test_ready_reset();
        test_full_free();
        test_init_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/stk_al_ctrl.md
STK_AL_CTRL -- requirements
Module: stk_al_ctrl

Interface
REQ-001 SHALL have parameter PTR_N, default 32: number of stack-entry pointers managed (power of two, >=4).
REQ-002 SHALL derive PTR_W = $clog2(PTR_N); free count is PTR_W+1 bits wide.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port arst_n  input  1  synchronous active-low reset, sampled on clk.
REQ-005 SHALL have port i_alloc_req  input  1  admission stage requests one pointer.
REQ-006 SHALL have port o_alloc_vld  output  1  pointer granted this cycle.
REQ-007 SHALL have port o_alloc_ptr  output  PTR_W  granted pointer, valid when o_alloc_vld.
REQ-008 SHALL have port i_free_vld  input  1  pointer returned by the pipeline.
REQ-009 SHALL have port i_free_ptr  input  PTR_W  pointer being returned.
REQ-010 SHALL have port o_empty  output  1  registered: no free pointer available.
REQ-011 SHALL have port o_busy  output  1  registered: controller initialising, no grants.
REQ-012 SHALL have port o_free_cnt  output  PTR_W+1  registered count of free pointers.
REQ-013 SHALL have port o_err  output  1  sticky double-free flag (see REQ-030).

Function
REQ-014 SHALL implement FSM states INIT and READY, encoded as a stk_pkg enum.
REQ-015 In INIT, SHALL write pointer value k into free-list slot k on init cycle k, k = 0..PTR_N-1, one per cycle.
REQ-016 SHALL transition INIT->READY after the write of PTR_N-1; o_free_cnt = PTR_N, o_busy = 0 on the first READY cycle.
REQ-017 In INIT, SHALL ignore i_alloc_req and i_free_vld (no state change, o_alloc_vld = 0).
REQ-018 Free list SHALL be a circular FIFO of PTR_N entries with PTR_W-bit head/tail pointers wrapping PTR_N-1 -> 0.
REQ-019 o_alloc_ptr SHALL present the head entry combinationally; o_alloc_vld = i_alloc_req & READY & ~o_empty (zero-cycle grant).
REQ-020 A grant SHALL pop the head at the clock edge; a subsequent request sees the next entry in the following cycle.
REQ-021 An accepted free (READY, count < PTR_N) SHALL write i_free_ptr at tail and advance tail.
REQ-022 Simultaneous grant and accepted free SHALL leave o_free_cnt unchanged; both pointers move.
REQ-023 When empty, a same-cycle free SHALL NOT bypass to the allocator: no grant; count becomes 1 next cycle.
REQ-024 A free when count == PTR_N SHALL be dropped and SHALL set o_err.
REQ-025 o_empty SHALL equal (o_free_cnt == 0) | (state == INIT), registered.
REQ-026 Freed pointers SHALL be granted in FIFO order.

Reset
REQ-027 Reset SHALL force state INIT, head = tail = 0, init counter 0, o_free_cnt 0, o_empty 1, o_busy 1, o_err 0, o_alloc_vld 0.
REQ-028 Reset asserted mid-INIT or mid-READY SHALL discard all state and restart the full PTR_N-cycle initialisation.
REQ-029 Free-list storage SHALL NOT be reset; initialisation overwrites it.

Configuration
REQ-030 With STK_AL_CTRL_DOUBLE_FREE_CHK_EN defined, SHALL keep a PTR_N-bit allocated bitmap (set on grant, clear on free, cleared in INIT); a free of an unallocated pointer SHALL be dropped and SHALL set o_err.
REQ-031 Without STK_AL_CTRL_DOUBLE_FREE_CHK_EN, SHALL omit the bitmap; o_err set only per REQ-024.

Structure
REQ-032 stk_pkg SHALL hold PTR_N default, PTR_W, ptr_t, and al_state_t {INIT, READY}.
REQ-033 Free-list FIFO storage SHALL be a sub-module stk_al_fl (write port, read port, no reset on data).
REQ-034 FSM, counters, bitmap and error logic SHALL reside in stk_al_ctrl.

Verification
REQ-035 Reset release, PTR_N=32 -> o_busy=1 for 32 cycles, then o_busy=0, o_free_cnt=32, o_empty=0.
REQ-036 32 back-to-back requests from READY -> pointers 0..31 in order, o_empty=1 after the 32nd, 33rd request gets no grant.
REQ-037 Empty list, free ptr 5 with alloc request same cycle -> no grant; next-cycle request grants 5, count 1->0.
REQ-038 Count 10, grant and free ptr 7 same cycle -> count stays 10; 7 granted after the 10 queued entries.
REQ-039 CHK_EN defined: free ptr 3 while 3 is unallocated -> drop, o_err=1 sticky, count unchanged; also free at count=32 -> o_err=1.
REQ-040 Reset asserted at init cycle 12 -> restart; 32 further cycles before o_busy=0, o_err cleared.
